seq_entry_tx: RTL and testbench

//  Player-side transmitter for the puzzle sequence interface.
//  - Builds a NUM_DIGITS-long code one digit at a time from the shaped rotate/verify pulses.
//  - Each committed digit goes out on a valid/ready beat to the sequence verifier.
//  - Sits between the button shapers and the verifier; also drives the puzzle display.

---
 rtl/seq_entry_tx_pkg.sv | 23 ++
 rtl/seq_entry_tx_digit_rotator.sv | 28 ++
 rtl/seq_entry_tx.sv | 160 ++++++++++++++++
 tb/tb_seq_entry_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_entry_tx_pkg.sv
// Shared definitions for the player-side sequence entry transmitter.
//   state_t       : entry FSM states
//   GS_*          : game controller state encodings seen on game_state
package seq_entry_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EDIT = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] GS_RESET  = 8'h00;
    localparam logic [7:0] GS_INTRO  = 8'h01;
    localparam logic [7:0] GS_PUZZLE = 8'h04;
    localparam logic [7:0] GS_WIN    = 8'h08;

    // Index width for a code of n digits; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_entry_tx_digit_rotator.sv
// Modulo-(DIGIT_MAX+1) digit counter used for the digit under edit.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   clear : force the count to 0 (dominates enable)
//   en    : advance by one, wrapping from DIGIT_MAX to 0
//   count : current digit value
module seq_entry_tx_digit_rotator #(
    parameter int unsigned DIGIT_W   = 4,
    parameter int unsigned DIGIT_MAX = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               en,
    output logic [DIGIT_W-1:0] count
);

    localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(DIGIT_MAX);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= (count == MAX_VAL) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_entry_tx.sv
// Player-side transmitter for the puzzle sequence interface. Builds a code one
// digit at a time from shaped rotate/verify pulses and sends each committed
// digit to the verifier on a valid/ready beat.
//   clk, rst     : clock, synchronous active-high reset
//   game_state   : game controller state; entry enabled at PUZZLE_STATE
//   one_sec      : 1 Hz tick, blinks the display cursor
//   rotate       : advance digit under edit
//   verify       : commit digit under edit
//   seq_ready    : verifier accepts the beat
//   seq_valid, seq_digit, seq_index, seq_last : outgoing beat
//   entry_abort  : one-cycle pulse when entry is cancelled by a state change
//   entry_word   : digits accepted so far, digit i at [i*DIGIT_W +: DIGIT_W]
//   cur_digit    : digit under edit (display)
//   cursor_on    : cursor blink phase (display)
module seq_entry_tx
    import seq_entry_tx_pkg::*;
#(
    parameter int unsigned DIGIT_W      = 4,
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DIGIT_MAX    = 9,
    parameter logic [7:0]  PUZZLE_STATE = GS_PUZZLE,
    localparam int unsigned IDX_W       = idx_width(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    game_state,
    input  logic                          one_sec,
    input  logic                          rotate,
    input  logic                          verify,
    input  logic                          seq_ready,
    output logic                          seq_valid,
    output logic [DIGIT_W-1:0]            seq_digit,
    output logic [IDX_W-1:0]              seq_index,
    output logic                          seq_last,
    output logic                          entry_abort,
    output logic [NUM_DIGITS*DIGIT_W-1:0] entry_word,
    output logic [DIGIT_W-1:0]            cur_digit,
    output logic                          cursor_on
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx;
    logic             puzzle;
    logic             hs;
    logic             abort;
    logic             rot_clear;
    logic             rot_en;

    assign puzzle = (game_state == PUZZLE_STATE);
    assign hs     = seq_valid && seq_ready;
    assign abort  = !puzzle && (state_q == ST_EDIT || state_q == ST_SEND);

    // Digit under edit is zero outside EDIT/SEND and restarts after every
    // accepted beat; rotate is dropped when verify arrives in the same cycle.
    assign rot_clear = (state_q == ST_IDLE) || (state_q == ST_DONE) || abort || hs;
    assign rot_en    = (state_q == ST_EDIT) && rotate && !verify;

    seq_entry_tx_digit_rotator #(
        .DIGIT_W   (DIGIT_W),
        .DIGIT_MAX (DIGIT_MAX)
    ) u_rotator (
        .clk   (clk),
        .rst   (rst),
        .clear (rot_clear),
        .en    (rot_en),
        .count (cur_digit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (puzzle) state_d = ST_EDIT;
            ST_EDIT: begin
                if (!puzzle)     state_d = ST_IDLE;
                else if (verify) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!puzzle)  state_d = ST_IDLE;
                else if (hs)  state_d = seq_last ? ST_DONE : ST_EDIT;
            end
            ST_DONE: if (!puzzle) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        seq_valid = 1'b0;
        if (state_q == ST_SEND) seq_valid = 1'b1;
    end

    // Beat, index, entry word and cursor registers. An abort clears everything
    // even when it coincides with a handshake: the verifier still sees the
    // beat, but the local entry restarts from scratch.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            seq_digit   <= '0;
            seq_index   <= '0;
            seq_last    <= 1'b0;
            entry_word  <= '0;
            cursor_on   <= 1'b0;
            entry_abort <= 1'b0;
        end else begin
            entry_abort <= abort;
            if (abort || (state_q == ST_DONE && !puzzle)) begin
                idx        <= '0;
                seq_digit  <= '0;
                seq_index  <= '0;
                seq_last   <= 1'b0;
                entry_word <= '0;
                cursor_on  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (puzzle) begin
                            idx        <= '0;
                            entry_word <= '0;
                            cursor_on  <= 1'b1;
                        end
                    end
                    ST_EDIT: begin
                        if (one_sec) cursor_on <= !cursor_on;
                        if (verify) begin
                            seq_digit <= cur_digit;
                            seq_index <= idx;
                            seq_last  <= (idx == LAST_IDX);
                        end
                    end
                    ST_SEND: begin
                        if (hs) begin
                            entry_word[idx*DIGIT_W +: DIGIT_W] <= seq_digit;
                            if (seq_last) begin
                                cursor_on <= 1'b0;
                            end else begin
                                idx       <= idx + 1'b1;
                                cursor_on <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_entry_tx.sv
module tb_seq_entry_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  game_state;
    logic        one_sec;
    logic        rotate;
    logic        verify;
    logic        seq_ready;
    logic        seq_valid;
    logic [3:0]  seq_digit;
    logic [1:0]  seq_index;
    logic        seq_last;
    logic        entry_abort;
    logic [15:0] entry_word;
    logic [3:0]  cur_digit;
    logic        cursor_on;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    seq_entry_tx #(
        .DIGIT_W      (4),
        .NUM_DIGITS   (4),
        .DIGIT_MAX    (9),
        .PUZZLE_STATE (8'h04)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .game_state  (game_state),
        .one_sec     (one_sec),
        .rotate      (rotate),
        .verify      (verify),
        .seq_ready   (seq_ready),
        .seq_valid   (seq_valid),
        .seq_digit   (seq_digit),
        .seq_index   (seq_index),
        .seq_last    (seq_last),
        .entry_abort (entry_abort),
        .entry_word  (entry_word),
        .cur_digit   (cur_digit),
        .cursor_on   (cursor_on)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rot_n(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            rotate = 1'b1;
            tick();
            rotate = 1'b0;
        end
    endtask

    task automatic pulse_verify();
        verify = 1'b1;
        tick();
        verify = 1'b0;
    endtask

    initial begin
        rst = 1'b1; game_state = 8'h04; one_sec = 1'b0;
        rotate = 1'b0; verify = 1'b0; seq_ready = 1'b0;
        tick(); tick();

        // 1: reset state
        check("rst_valid", 32'(seq_valid), 32'h0);
        check("rst_word", 32'(entry_word), 32'h0);
        check("rst_cur", 32'(cur_digit), 32'h0);
        check("rst_abort", 32'(entry_abort), 32'h0);
        check("rst_cursor", 32'(cursor_on), 32'h0);
        rst = 1'b0;
        tick();
        check("edit_cursor", 32'(cursor_on), 32'h1);

        // 2: rotate sweep wraps after 9, then send digit 3 at index 0
        for (int unsigned i = 1; i <= 10; i++) begin
            rot_n(1);
            check("sweep", 32'(cur_digit), (i == 10) ? 32'h0 : 32'(i));
        end
        rot_n(3);
        seq_ready = 1'b1;
        pulse_verify();
        check("b0_valid", 32'(seq_valid), 32'h1);
        check("b0_digit", 32'(seq_digit), 32'h3);
        check("b0_index", 32'(seq_index), 32'h0);
        check("b0_last", 32'(seq_last), 32'h0);
        tick();
        check("b0_done", 32'(seq_valid), 32'h0);
        check("b0_word", 32'(entry_word), 32'h0003);

        // 5: rotate and verify together with digit 7
        rot_n(7);
        rotate = 1'b1; verify = 1'b1;
        tick();
        rotate = 1'b0; verify = 1'b0;
        check("rv_digit", 32'(seq_digit), 32'h7);
        check("rv_index", 32'(seq_index), 32'h1);
        check("rv_cur", 32'(cur_digit), 32'h7);
        tick();
        check("rv_word", 32'(entry_word), 32'h0073);
        check("rv_next", 32'(cur_digit), 32'h0);

        // 4: stall for 5 cycles, rotate/verify ignored while the beat waits
        seq_ready = 1'b0;
        rot_n(5);
        pulse_verify();
        for (int unsigned i = 0; i < 5; i++) begin
            rotate = 1'b1; verify = i[0];
            tick();
            check("st_valid", 32'(seq_valid), 32'h1);
            check("st_digit", 32'(seq_digit), 32'h5);
            check("st_index", 32'(seq_index), 32'h2);
            check("st_cur", 32'(cur_digit), 32'h5);
        end
        rotate = 1'b0; verify = 1'b0; seq_ready = 1'b1;
        tick();
        check("st_done", 32'(seq_valid), 32'h0);
        check("st_word", 32'(entry_word), 32'h0573);

        // 6: abort while the last beat is pending
        seq_ready = 1'b0;
        rot_n(2);
        pulse_verify();
        check("ab_valid", 32'(seq_valid), 32'h1);
        check("ab_last", 32'(seq_last), 32'h1);
        game_state = 8'h01;
        tick();
        check("ab_withdrawn", 32'(seq_valid), 32'h0);
        check("ab_pulse", 32'(entry_abort), 32'h1);
        check("ab_word", 32'(entry_word), 32'h0);
        check("ab_cur", 32'(cur_digit), 32'h0);
        tick();
        check("ab_pulse_end", 32'(entry_abort), 32'h0);
        game_state = 8'h04; seq_ready = 1'b1;
        tick();
        check("re_cursor", 32'(cursor_on), 32'h1);
        one_sec = 1'b1; tick(); one_sec = 1'b0;
        check("blink_off", 32'(cursor_on), 32'h0);
        one_sec = 1'b1; tick(); one_sec = 1'b0;
        check("blink_on", 32'(cursor_on), 32'h1);

        // 3: full code 1,2,3,4
        for (int unsigned k = 0; k < 4; k++) begin
            rot_n(k + 1);
            pulse_verify();
            check("fc_valid", 32'(seq_valid), 32'h1);
            check("fc_index", 32'(seq_index), k);
            check("fc_digit", 32'(seq_digit), k + 1);
            check("fc_last", 32'(seq_last), (k == 3) ? 32'h1 : 32'h0);
            tick();
            check("fc_done", 32'(seq_valid), 32'h0);
        end
        check("fc_word", 32'(entry_word), 32'h4321);
        check("fc_cursor", 32'(cursor_on), 32'h0);
        for (int unsigned i = 0; i < 3; i++) begin
            rotate = 1'b1; verify = 1'b1;
            tick();
            rotate = 1'b0; verify = 1'b0;
            tick();
            check("dn_valid", 32'(seq_valid), 32'h0);
            check("dn_cur", 32'(cur_digit), 32'h0);
            check("dn_word", 32'(entry_word), 32'h4321);
        end

        // Leaving DONE: back to idle with no abort pulse
        game_state = 8'h00;
        tick();
        check("dx_abort", 32'(entry_abort), 32'h0);
        check("dx_word", 32'(entry_word), 32'h0);
        tick();
        check("dx_abort2", 32'(entry_abort), 32'h0);

        // Reset in the middle of a pending beat
        game_state = 8'h04; seq_ready = 1'b0;
        tick();
        rot_n(6);
        pulse_verify();
        check("mr_valid", 32'(seq_valid), 32'h1);
        rst = 1'b1;
        tick();
        check("mr_withdrawn", 32'(seq_valid), 32'h0);
        check("mr_abort", 32'(entry_abort), 32'h0);
        check("mr_cur", 32'(cur_digit), 32'h0);
        rst = 1'b0;
        tick();
        check("mr_abort2", 32'(entry_abort), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
